// File: rtl/rgb_frame_xfer_ctrl.sv
// Raster-order frame read sequencer feeding the RGB565->RGB888 converter.
// Define XFER_BYTE_SWAP_EN to byte-swap each source word for byte-swapped sources.
module rgb_frame_xfer_ctrl #(
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned H_ACT    = 320,
    parameter int unsigned V_ACT    = 240,
    parameter int unsigned SRC_BASE = 0,
    parameter int unsigned DST_BASE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_hold,
    output logic              oSrcEn,
    output logic [ADDR_W-1:0] oSrcAddr,
    input  logic [15:0]       iSrcData,
    output logic              o_cvt_en,
    output logic [ADDR_W-1:0] o_cvt_addr,
    output logic [15:0]       o_cvt_data,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned X_W = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam int unsigned Y_W = (V_ACT > 1) ? $clog2(V_ACT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [X_W-1:0]     r_x;
    logic [X_W-1:0]     w_x_cur;
    logic [X_W-1:0]     w_x_nxt;
    logic [Y_W-1:0]     r_y;
    logic [Y_W-1:0]     w_y_cur;
    logic [Y_W-1:0]     w_y_nxt;
    logic [ADDR_W-1:0]  r_ptr;
    logic [ADDR_W-1:0]  w_ptr_cur;
    logic [ADDR_W-1:0]  w_ptr_nxt;
    logic               w_issue;
    logic               w_last_px;
    logic               w_done_nxt;
    logic               w_kill;
    logic               r_rd_v;
    logic [ADDR_W-1:0]  r_off;
    logic [15:0]        r_data_last;
    logic [15:0]        w_src_word;

`ifdef XFER_BYTE_SWAP_EN
    assign w_src_word = {iSrcData[7:0], iSrcData[15:8]};
`else
    assign w_src_word = iSrcData;
`endif

    // Abort only acts on an active transfer.
    assign w_kill = i_abort && (r_state != S_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, read issue and raster counter advance
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_done_nxt  = 1'b0;
        w_x_cur     = (r_state == S_IDLE) ? '0 : r_x;
        w_y_cur     = (r_state == S_IDLE) ? '0 : r_y;
        w_ptr_cur   = (r_state == S_IDLE) ? '0 : r_ptr;
        w_last_px   = (w_x_cur == X_W'(H_ACT - 1)) && (w_y_cur == Y_W'(V_ACT - 1));
        w_x_nxt     = w_x_cur;
        w_y_nxt     = w_y_cur;
        w_ptr_nxt   = w_ptr_cur;

        case (r_state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    w_issue     = !i_hold;
                    w_state_nxt = (!i_hold && w_last_px) ? S_DRAIN : S_READ;
                end
            end
            S_READ: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (!i_hold) begin
                    w_issue = 1'b1;
                    if (w_last_px) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Last pixel is on the converter port once no read is outstanding.
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_rd_v && !oSrcEn) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_issue) begin
            w_ptr_nxt = w_ptr_cur + ADDR_W'(1);
            if (w_x_cur == X_W'(H_ACT - 1)) begin
                w_x_nxt = '0;
                w_y_nxt = w_y_cur + Y_W'(1);
            end else begin
                w_x_nxt = w_x_cur + X_W'(1);
            end
        end
    end

    // Counters, read port and converter pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_ptr       <= '0;
            oSrcEn      <= 1'b0;
            oSrcAddr    <= '0;
            r_off       <= '0;
            r_rd_v      <= 1'b0;
            o_cvt_addr  <= '0;
            r_data_last <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            r_x    <= w_x_nxt;
            r_y    <= w_y_nxt;
            r_ptr  <= w_ptr_nxt;
            oSrcEn <= w_issue;
            if (w_issue) begin
                oSrcAddr <= ADDR_W'(SRC_BASE) + w_ptr_cur;
                r_off    <= w_ptr_cur;
            end
            r_rd_v <= oSrcEn && !w_kill;
            if (oSrcEn && !w_kill) begin
                o_cvt_addr <= ADDR_W'(DST_BASE) + r_off;
            end
            if (r_rd_v) begin
                r_data_last <= w_src_word;
            end
            o_busy <= (w_state_nxt != S_IDLE);
            o_done <= w_done_nxt;
        end
    end

    // Source data arrives in the rd_v cycle; between pixels the last word is held.
    assign o_cvt_en   = r_rd_v;
    assign o_cvt_data = r_rd_v ? w_src_word : r_data_last;

endmodule

// File: tb/tb_rgb_frame_xfer_ctrl.sv
// Scoreboard bench for rgb_frame_xfer_ctrl with a small raster model and memory.
// Expected data follows XFER_BYTE_SWAP_EN when defined.
module tb_rgb_frame_xfer_ctrl;

    localparam int unsigned AW = 17;
    localparam int unsigned H  = 4;
    localparam int unsigned V  = 3;
    localparam int unsigned N  = H * V;
    localparam int unsigned SB = 'h100;
    localparam int unsigned DB = 'h40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic          i_hold = 1'b0;
    logic          oSrcEn;
    logic [AW-1:0] oSrcAddr;
    logic [15:0]   iSrcData = 16'h0;
    logic          o_cvt_en;
    logic [AW-1:0] o_cvt_addr;
    logic [15:0]   o_cvt_data;
    logic          o_busy;
    logic          o_done;

    rgb_frame_xfer_ctrl #(
        .ADDR_W(AW), .H_ACT(H), .V_ACT(V), .SRC_BASE(SB), .DST_BASE(DB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort), .i_hold(i_hold),
        .oSrcEn(oSrcEn), .oSrcAddr(oSrcAddr), .iSrcData(iSrcData),
        .o_cvt_en(o_cvt_en), .o_cvt_addr(o_cvt_addr), .o_cvt_data(o_cvt_data),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    // Source memory: word = address XOR a per-frame mask, one cycle read latency.
    logic [15:0] mask = 16'h0;
    always @(posedge clk) if (oSrcEn) iSrcData <= mask ^ oSrcAddr[15:0];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_word(input logic [15:0] w);
`ifdef XFER_BYTE_SWAP_EN
        return {w[7:0], w[15:8]};
`else
        return w;
`endif
    endfunction

    // Scoreboard queues and monitor statistics
    logic [AW-1:0]    src_q[$];
    logic [AW+15:0]   cvt_q[$];
    int cyc = 0, c0 = 0;
    int src_cnt, cvt_cnt, done_cnt, busy_cnt, first_src, last_src, first_cvt, last_cvt;
    int done_rel, last_busy;
    logic [15:0] first_cvt_data;
    logic prev_src = 1'b0;
    logic hold_s = 1'b0;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        hold_s <= i_hold;
    end

    always @(negedge clk) begin
        int rel;
        logic [AW-1:0]  es;
        logic [AW+15:0] ec;
        rel = cyc - c0;
        if (hold_s) chk("no_read_while_hold", 32'(oSrcEn), 32'd0);
        if (oSrcEn) begin
            src_cnt++;
            if (src_cnt == 1) first_src = rel;
            last_src = rel;
            if (src_q.size() == 0) chk("src_unexpected", 32'(oSrcAddr), 32'hFFFF_FFFF);
            else begin
                es = src_q.pop_front();
                chk("src_addr", 32'(oSrcAddr), 32'(es));
            end
        end
        if (o_cvt_en) begin
            cvt_cnt++;
            if (cvt_cnt == 1) begin
                first_cvt = rel;
                first_cvt_data = o_cvt_data;
            end
            last_cvt = rel;
            chk("cvt_follows_src", 32'(prev_src), 32'd1);
            if (cvt_q.size() == 0) chk("cvt_unexpected", 32'(o_cvt_addr), 32'hFFFF_FFFF);
            else begin
                ec = cvt_q.pop_front();
                chk("cvt_addr", 32'(o_cvt_addr), 32'(ec[AW+15:16]));
                chk("cvt_data", 32'(o_cvt_data), 32'(ec[15:0]));
            end
        end
        if (o_done) begin
            done_cnt++;
            done_rel = rel;
            chk("done_busy_low", 32'(o_busy), 32'd0);
        end
        if (o_busy) begin
            busy_cnt++;
            last_busy = rel;
        end
        prev_src = oSrcEn;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        src_cnt = 0; cvt_cnt = 0; done_cnt = 0; busy_cnt = 0;
        first_src = -1; last_src = -1; first_cvt = -1; last_cvt = -1;
        done_rel = -1; last_busy = -1;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_src_en"},   32'(oSrcEn), 0);
        chk({tag, "_src_addr"}, 32'(oSrcAddr), 0);
        chk({tag, "_cvt_en"},   32'(o_cvt_en), 0);
        chk({tag, "_cvt_addr"}, 32'(o_cvt_addr), 0);
        chk({tag, "_cvt_data"}, 32'(o_cvt_data), 0);
        chk({tag, "_busy"},     32'(o_busy), 0);
        chk({tag, "_done"},     32'(o_done), 0);
    endtask

    // Fill scoreboard with the full raster for the current mask, then pulse start.
    task automatic begin_frame(input logic [15:0] m);
        logic [AW-1:0] a;
        mask = m;
        clear_stats();
        src_q.delete();
        cvt_q.delete();
        for (int p = 0; p < int'(N); p++) begin
            a = AW'(SB + p);
            src_q.push_back(a);
            cvt_q.push_back({AW'(DB + p), exp_word(m ^ a[15:0])});
        end
        i_start = 1'b1;
        @(posedge clk);
        c0 = cyc;
        #1;
        i_start = 1'b0;
    endtask

    // Run a frame to completion; cycle c drives values sampled at the edge ending it.
    task automatic run_frame(input logic [15:0] m, input int hold_lo, input int hold_hi,
                             input int start_at, input bit rnd_hold);
        begin_frame(m);
        for (int c = 1; c < 400 && done_cnt == 0; c++) begin
            i_hold  = (c >= hold_lo && c <= hold_hi) || (rnd_hold && ($urandom % 3 == 0));
            i_start = (c == start_at);
            tick();
        end
        i_hold = 1'b0;
        i_start = 1'b0;
        tick();
        tick();
        chk("src_count", 32'(src_cnt), N);
        chk("cvt_count", 32'(cvt_cnt), N);
        chk("done_count", 32'(done_cnt), 1);
        chk("first_src_cycle", 32'(first_src), 1);
        chk("first_cvt_cycle", 32'(first_cvt), 2);
        chk("last_cvt_cycle", 32'(last_cvt), 32'(last_src + 1));
        chk("done_cycle", 32'(done_rel), 32'(last_src + 2));
        chk("busy_end", 32'(last_busy), 32'(last_src + 1));
        chk("queues_empty", 32'(src_q.size() + cvt_q.size()), 0);
    endtask

    initial begin
        clear_stats();
        #1;
        check_outputs_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Plain frame: source word equals address.
        run_frame(16'h0000, -1, -1, -1, 1'b0);
        chk("plain_done_at_14", 32'(done_rel), 14);
        chk("plain_first_data", 32'(first_cvt_data), 32'(exp_word(16'h0100)));

        // Hold in cycles 3..5 stretches the frame by 3.
        run_frame(16'h0000, 3, 5, -1, 1'b0);
        chk("hold_done_at_17", 32'(done_rel), 17);
        chk("hold_last_src", 32'(last_src), 15);

        // Start pulsed mid-frame is ignored.
        run_frame(16'h0000, -1, -1, 5, 1'b0);
        chk("restart_ignored_done", 32'(done_rel), 14);

        // Byte-swap sample: first source word is 0x1234.
        run_frame(16'h1234 ^ 16'h0100, -1, -1, -1, 1'b0);
        chk("swap_first_data", 32'(first_cvt_data), 32'(exp_word(16'h1234)));

        // Abort sampled at the end of cycle 6.
        begin_frame(16'h0000);
        for (int c = 1; c <= 12; c++) begin
            i_abort = (c == 6);
            tick();
        end
        i_abort = 1'b0;
        chk("abort_src_count", 32'(src_cnt), 6);
        chk("abort_cvt_count", 32'(cvt_cnt), 5);
        chk("abort_last_cvt", 32'(last_cvt), 6);
        chk("abort_last_busy", 32'(last_busy), 6);
        chk("abort_no_done", 32'(done_cnt), 0);
        run_frame(16'h0000, -1, -1, -1, 1'b0);
        chk("after_abort_done", 32'(done_rel), 14);

        // Start together with abort in IDLE does nothing.
        clear_stats();
        i_start = 1'b1;
        i_abort = 1'b1;
        tick();
        i_start = 1'b0;
        i_abort = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        chk("start_abort_no_read", 32'(src_cnt), 0);
        chk("start_abort_no_busy", 32'(busy_cnt), 0);

        // Reset asserted in cycle 5 clears outputs immediately.
        begin_frame(16'h0000);
        for (int c = 1; c < 5; c++) tick();
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("midreset_no_done", 32'(done_cnt), 0);
        run_frame(16'h0000, -1, -1, -1, 1'b0);
        chk("after_reset_done", 32'(done_rel), 14);

        // Randomised holds and data masks.
        for (int f = 0; f < 5; f++) begin
            run_frame(16'($urandom), -1, -1, -1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
